// File: rtl/mel_frame_serializer.sv
// Mel frame serializer: captures a parallel mel vector on valid_i and streams it out one value per beat.
// Optional build macro MEL_SER_DOUBLE_BUF_EN adds a pending frame buffer that absorbs one early frame.
module mel_frame_serializer #(
  parameter int N_MELS  = 40,
  parameter int ACCUM_W = 54,
  parameter int IDX_W   = $clog2(N_MELS)
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [ACCUM_W-1:0] mel_i [N_MELS],
  input  logic               valid_i,
  output logic [ACCUM_W-1:0] data_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               last_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               busy_o,
  output logic               overrun_o
);

  // state  | meaning
  // S_IDLE | no frame held, waiting for valid_i
  // S_SEND | presenting buf[idx] on data_o until the final beat is accepted
  typedef enum logic {S_IDLE, S_SEND} state_t;

  localparam logic [IDX_W-1:0] LP_IDX_LAST = IDX_W'(N_MELS - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [ACCUM_W-1:0] r_data;
  logic               r_overrun;
  logic [ACCUM_W-1:0] r_buf [N_MELS];

  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [IDX_W-1:0]   w_idx_inc;
  logic [ACCUM_W-1:0] w_data_nxt;
  logic               w_load_act;
  logic               w_ovr_set;
  logic               w_at_last;

`ifdef MEL_SER_DOUBLE_BUF_EN
  logic [ACCUM_W-1:0] r_pend_buf [N_MELS];
  logic               r_pend_full;
  logic               w_pend_full_nxt;
  logic               w_load_pend;
  logic               w_move_pend;
`endif

  assign w_at_last = (r_idx == LP_IDX_LAST);
  assign w_idx_inc = r_idx + IDX_W'(1);

  assign data_o    = r_data;
  assign idx_o     = r_idx;
  assign valid_o   = (r_state == S_SEND);
  assign last_o    = (r_state == S_SEND) && w_at_last;
  assign overrun_o = r_overrun;
`ifdef MEL_SER_DOUBLE_BUF_EN
  assign busy_o    = (r_state == S_SEND) || r_pend_full;
`else
  assign busy_o    = (r_state == S_SEND);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_load_act  = 1'b0;
    w_ovr_set   = 1'b0;
`ifdef MEL_SER_DOUBLE_BUF_EN
    w_pend_full_nxt = r_pend_full;
    w_load_pend     = 1'b0;
    w_move_pend     = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (valid_i) begin
          w_load_act  = 1'b1;
          w_idx_nxt   = '0;
          w_data_nxt  = mel_i[0];
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (ready_i && !w_at_last) begin
          w_idx_nxt  = w_idx_inc;
          w_data_nxt = r_buf[w_idx_inc];
        end
`ifdef MEL_SER_DOUBLE_BUF_EN
        // On the final beat the pending frame moves up, and a coincident new frame refills pending.
        if (ready_i && w_at_last) begin
          w_idx_nxt = '0;
          if (r_pend_full) begin
            w_move_pend     = 1'b1;
            w_data_nxt      = r_pend_buf[0];
            w_load_pend     = valid_i;
            w_pend_full_nxt = valid_i;
          end else if (valid_i) begin
            w_load_act = 1'b1;
            w_data_nxt = mel_i[0];
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (valid_i) begin
          if (!r_pend_full) begin
            w_load_pend     = 1'b1;
            w_pend_full_nxt = 1'b1;
          end else begin
            w_ovr_set = 1'b1;
          end
        end
`else
        if (ready_i && w_at_last) begin
          w_idx_nxt = '0;
          if (valid_i) begin
            w_load_act = 1'b1;
            w_data_nxt = mel_i[0];
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (valid_i) begin
          w_ovr_set = 1'b1;
        end
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_data    <= '0;
      r_overrun <= 1'b0;
`ifdef MEL_SER_DOUBLE_BUF_EN
      r_pend_full <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_data  <= w_data_nxt;
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end
`ifdef MEL_SER_DOUBLE_BUF_EN
      r_pend_full <= w_pend_full_nxt;
`endif
    end
  end

  // Frame storage carries no reset; contents are only read while a frame is marked held.
  always_ff @(posedge clk_i) begin
    if (w_load_act) begin
      r_buf <= mel_i;
    end
`ifdef MEL_SER_DOUBLE_BUF_EN
    else if (w_move_pend) begin
      r_buf <= r_pend_buf;
    end
    if (w_load_pend) begin
      r_pend_buf <= mel_i;
    end
`endif
  end

endmodule

// File: tb/tb_mel_frame_serializer.sv
// Self-checking bench for mel_frame_serializer against a queue-based beat model.
module tb_mel_frame_serializer;
  localparam int N  = 40;
  localparam int W  = 54;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          valid;
  logic          ready;
  logic [W-1:0]  mel [N];
  logic [W-1:0]  data_o;
  logic [IW-1:0] idx_o;
  logic          last_o, valid_o, busy_o, overrun_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] val;
    int           idx;
  } beat_t;

  beat_t        m_q[$];
  logic         m_ovr;
  logic         e_valid, e_last, e_busy, e_ovr;
  logic [W-1:0] e_data;
  int           e_idx;

  always #5 clk = ~clk;

  mel_frame_serializer dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .mel_i    (mel),
    .valid_i  (valid),
    .data_o   (data_o),
    .idx_o    (idx_o),
    .last_o   (last_o),
    .valid_o  (valid_o),
    .ready_i  (ready),
    .busy_o   (busy_o),
    .overrun_o(overrun_o)
  );

  // Model: the queue holds every beat still owed downstream; a frame is accepted only if it fits.
  function automatic void model_step();
    bit xfer, accept;
    int sz;
    if (!reset_n) begin
      m_q.delete();
      m_ovr = 1'b0;
      return;
    end
    sz   = m_q.size();
    xfer = (sz > 0) && ready;
`ifdef MEL_SER_DOUBLE_BUF_EN
    accept = valid && (sz <= N || (sz == N + 1 && xfer));
`else
    accept = valid && (sz == 0 || (sz == 1 && xfer));
`endif
    if (xfer) void'(m_q.pop_front());
    if (accept) begin
      for (int k = 0; k < N; k++) m_q.push_back('{val: mel[k], idx: k});
    end else if (valid) begin
      m_ovr = 1'b1;
    end
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    e_valid = (m_q.size() > 0);
    e_busy  = e_valid;
    e_ovr   = m_ovr;
    e_data  = '0;
    e_idx   = 0;
    e_last  = 1'b0;
    if (e_valid) begin
      e_data = m_q[0].val;
      e_idx  = m_q[0].idx;
      e_last = (m_q[0].idx == N - 1);
    end
  endtask

  task automatic fill_random();
    logic [63:0] r;
    for (int k = 0; k < N; k++) begin
      r = {$urandom(), $urandom()};
      mel[k] = r[W-1:0];
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    valid   = 1'b0;
    ready   = 1'b1;
    tick();
    tick();
    checks++;
    if ({valid_o, last_o, busy_o, overrun_o, idx_o, data_o} !== '0) begin
      errors++;
      $display("FAIL reset_state got v%b l%b b%b o%b idx%0d data%0h required all zero",
               valid_o, last_o, busy_o, overrun_o, idx_o, data_o);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int nlast = 0;
    for (int k = 0; k < N; k++) mel[k] = W'(k * 1000 + 7);
    ready = 1'b1;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || idx_o !== '0 || data_o !== W'(7)) begin
      errors++;
      $display("FAIL basic_first got v%b idx%0d data%0d required v1 idx0 data7", valid_o, idx_o, data_o);
    end
    for (int c = 0; c < 45; c++) begin
      checks++;
      if ({valid_o, last_o, busy_o, overrun_o} !== {e_valid, e_last, e_busy, e_ovr}) begin
        errors++;
        $display("FAIL basic_ctl c=%0d got v%b l%b b%b o%b required v%b l%b b%b o%b", c,
                 valid_o, last_o, busy_o, overrun_o, e_valid, e_last, e_busy, e_ovr);
      end
      if (e_valid) begin
        checks++;
        if (data_o !== e_data || idx_o !== IW'(e_idx)) begin
          errors++;
          $display("FAIL basic_beat c=%0d got idx%0d data%0d required idx%0d data%0d", c, idx_o, data_o, e_idx, e_data);
        end
      end
      if (last_o === 1'b1) nlast++;
      tick();
    end
    checks++;
    if (nlast != 1) begin
      errors++;
      $display("FAIL basic_last_count got %0d required 1", nlast);
    end
  endtask

  task automatic test_backpressure();
    int nx = 0;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    fill_random();
    ready = 1'b1;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int c = 0; c < 90; c++) begin
      ready = pat[c % 4];
      checks++;
      if ({valid_o, last_o, busy_o, overrun_o} !== {e_valid, e_last, e_busy, e_ovr}) begin
        errors++;
        $display("FAIL bp_ctl c=%0d got v%b l%b b%b o%b required v%b l%b b%b o%b", c,
                 valid_o, last_o, busy_o, overrun_o, e_valid, e_last, e_busy, e_ovr);
      end
      if (e_valid) begin
        checks++;
        if (data_o !== e_data || idx_o !== IW'(e_idx)) begin
          errors++;
          $display("FAIL bp_beat c=%0d got idx%0d data%0h required idx%0d data%0h", c, idx_o, data_o, e_idx, e_data);
        end
      end
      if (valid_o === 1'b1 && ready) begin
        checks++;
        if (idx_o !== IW'(nx)) begin
          errors++;
          $display("FAIL bp_order got idx%0d required idx%0d", idx_o, nx);
        end
        nx++;
      end
      tick();
    end
    ready = 1'b1;
    checks++;
    if (nx != N) begin
      errors++;
      $display("FAIL bp_xfer_count got %0d required %0d", nx, N);
    end
  endtask

  task automatic test_back_to_back();
    bit found = 0;
    fill_random();
    ready = 1'b1;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      if (e_valid && e_idx == N - 1) begin
        for (int k = 0; k < N; k++) mel[k] = W'(k + 500000);
        valid = 1'b1;
        tick();
        valid = 1'b0;
        found = 1;
      end else begin
        tick();
      end
    end
    checks++;
    if (!found || valid_o !== 1'b1 || idx_o !== '0 || data_o !== W'(500000) || overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first found%0d got v%b idx%0d data%0d o%b required v1 idx0 data500000 o0",
               found, valid_o, idx_o, data_o, overrun_o);
    end
    for (int c = 0; c < 45; c++) begin
      checks++;
      if ({valid_o, last_o, busy_o, overrun_o} !== {e_valid, e_last, e_busy, e_ovr}) begin
        errors++;
        $display("FAIL b2b_ctl c=%0d got v%b l%b b%b o%b required v%b l%b b%b o%b", c,
                 valid_o, last_o, busy_o, overrun_o, e_valid, e_last, e_busy, e_ovr);
      end
      if (e_valid) begin
        checks++;
        if (data_o !== e_data || idx_o !== IW'(e_idx)) begin
          errors++;
          $display("FAIL b2b_beat c=%0d got idx%0d data%0d required idx%0d data%0d", c, idx_o, data_o, e_idx, e_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_max_width();
    int nones = 0;
    for (int k = 0; k < N; k++) mel[k] = '1;
    ready = 1'b1;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int c = 0; c < 42; c++) begin
      checks++;
      if ({valid_o, last_o, busy_o} !== {e_valid, e_last, e_busy}) begin
        errors++;
        $display("FAIL max_ctl c=%0d got v%b l%b b%b required v%b l%b b%b", c,
                 valid_o, last_o, busy_o, e_valid, e_last, e_busy);
      end
      if (valid_o === 1'b1 && data_o === {W{1'b1}}) nones++;
      tick();
    end
    checks++;
    if (nones != N) begin
      errors++;
      $display("FAIL max_all_ones got %0d beats required %0d", nones, N);
    end
  endtask

  task automatic test_overrun();
    bit found = 0;
    fill_random();
    ready = 1'b1;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (e_valid && e_idx == 10) begin
        fill_random();
        valid = 1'b1;
        tick();
        valid = 1'b0;
        found = 1;
      end else begin
        tick();
      end
    end
    checks++;
`ifdef MEL_SER_DOUBLE_BUF_EN
    if (!found || overrun_o !== 1'b0 || idx_o !== IW'(11)) begin
      errors++;
      $display("FAIL ovr_flag found%0d got o%b idx%0d required o0 idx11", found, overrun_o, idx_o);
    end
`else
    if (!found || overrun_o !== 1'b1 || idx_o !== IW'(11)) begin
      errors++;
      $display("FAIL ovr_flag found%0d got o%b idx%0d required o1 idx11", found, overrun_o, idx_o);
    end
`endif
    for (int c = 0; c < 80; c++) begin
      checks++;
      if ({valid_o, last_o, busy_o, overrun_o} !== {e_valid, e_last, e_busy, e_ovr}) begin
        errors++;
        $display("FAIL ovr_ctl c=%0d got v%b l%b b%b o%b required v%b l%b b%b o%b", c,
                 valid_o, last_o, busy_o, overrun_o, e_valid, e_last, e_busy, e_ovr);
      end
      if (e_valid) begin
        checks++;
        if (data_o !== e_data || idx_o !== IW'(e_idx)) begin
          errors++;
          $display("FAIL ovr_beat c=%0d got idx%0d data%0h required idx%0d data%0h", c, idx_o, data_o, e_idx, e_data);
        end
      end
      tick();
    end
    checks++;
    if (valid_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL ovr_idle got v%b b%b required v0 b0", valid_o, busy_o);
    end
  endtask

  task automatic test_reset_mid();
    fill_random();
    ready = 1'b1;
    valid = 1'b1;
    tick();
    valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (e_valid && e_idx == 5) valid = 1'b1;
      if (e_valid && e_idx == 20) begin
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        break;
      end
      tick();
      valid = 1'b0;
    end
    checks++;
    if ({valid_o, busy_o, overrun_o, idx_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_state got v%b b%b o%b idx%0d required v0 b0 o0 idx0", valid_o, busy_o, overrun_o, idx_o);
    end
    fill_random();
    valid = 1'b1;
    tick();
    valid = 1'b0;
    checks++;
    if (valid_o !== 1'b1 || idx_o !== '0 || data_o !== mel[0]) begin
      errors++;
      $display("FAIL rstmid_restart got v%b idx%0d data%0h required v1 idx0 data%0h", valid_o, idx_o, data_o, mel[0]);
    end
    for (int c = 0; c < 42; c++) begin
      checks++;
      if ({valid_o, last_o, busy_o, overrun_o} !== {e_valid, e_last, e_busy, e_ovr}) begin
        errors++;
        $display("FAIL rstmid_ctl c=%0d got v%b l%b b%b o%b required v%b l%b b%b o%b", c,
                 valid_o, last_o, busy_o, overrun_o, e_valid, e_last, e_busy, e_ovr);
      end
      if (e_valid) begin
        checks++;
        if (data_o !== e_data || idx_o !== IW'(e_idx)) begin
          errors++;
          $display("FAIL rstmid_beat c=%0d got idx%0d data%0h required idx%0d data%0h", c, idx_o, data_o, e_idx, e_data);
        end
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      valid = ($urandom_range(0, 49) == 0);
      if (valid) fill_random();
      ready = ($urandom_range(0, 3) != 0);
      checks++;
      if ({valid_o, last_o, busy_o, overrun_o} !== {e_valid, e_last, e_busy, e_ovr}) begin
        errors++;
        $display("FAIL rand_ctl c=%0d got v%b l%b b%b o%b required v%b l%b b%b o%b", c,
                 valid_o, last_o, busy_o, overrun_o, e_valid, e_last, e_busy, e_ovr);
      end
      if (e_valid) begin
        checks++;
        if (data_o !== e_data || idx_o !== IW'(e_idx)) begin
          errors++;
          $display("FAIL rand_beat c=%0d got idx%0d data%0h required idx%0d data%0h", c, idx_o, data_o, e_idx, e_data);
        end
      end
      tick();
    end
    valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    valid   = 1'b0;
    ready   = 1'b0;
    m_ovr   = 1'b0;
    for (int k = 0; k < N; k++) mel[k] = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_max_width();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
